// File: rtl/stfq_pkg.sv
// Shared widths, types and the saturating rank adder for the STFQ rank path.
package stfq_pkg;

  localparam int RANK_W = 32;
  localparam int LEN_W  = 16;
  localparam int COST_W = 16;

  typedef logic [RANK_W-1:0] rank_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [COST_W-1:0] cost_t;

  localparam rank_t RANK_MAX = 32'hFFFF_FFFF;

  // Ranks clamp at RANK_MAX instead of wrapping, so ordering is never inverted.
  function automatic rank_t sat_add(input rank_t a, input rank_t b);
    logic [RANK_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RANK_W] ? RANK_MAX : sum[RANK_W-1:0];
  endfunction

endpackage

// File: rtl/flow_occupancy.sv
// Per-flow packet counters; a simultaneous inc and dec on one flow cancel out.
module flow_occupancy #(
  parameter int FLOWS = 10,
  parameter int SIZE  = 50,
  parameter int FID_W = $clog2(FLOWS),
  parameter int CNT_W = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [FID_W-1:0] inc_flow,
  input  logic             dec,
  input  logic [FID_W-1:0] dec_flow,
  output logic [FLOWS-1:0] full
);

  localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] OCC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] OCC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] occ_r [FLOWS];
  logic [FLOWS-1:0] inc_vec_s;
  logic [FLOWS-1:0] dec_vec_s;

  // Decode the inc/dec strobes per flow and flag flows at the limit.
  always_comb begin
    inc_vec_s = {FLOWS{1'b0}};
    dec_vec_s = {FLOWS{1'b0}};
    full      = {FLOWS{1'b0}};
    for (int i = 0; i < FLOWS; i++) begin
      inc_vec_s[i] = inc && (int'(inc_flow) == i);
      dec_vec_s[i] = dec && (int'(dec_flow) == i);
      full[i]      = (occ_r[i] == OCC_MAX);
    end
  end

  // Counter update; saturates at both ends.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLOWS; i++) begin
      if (rst) begin
        occ_r[i] <= OCC_ZERO;
      end else begin
        case ({inc_vec_s[i], dec_vec_s[i]})
          2'b10: if (occ_r[i] != OCC_MAX)  occ_r[i] <= occ_r[i] + OCC_ONE;
          2'b01: if (occ_r[i] != OCC_ZERO) occ_r[i] <= occ_r[i] - OCC_ONE;
          default: occ_r[i] <= occ_r[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/stfq_rank_computer.sv
// Computes Start-Time Fair Queueing ranks for classified packets and pushes them
// into the per-flow rank store, guarding against store overflow.
module stfq_rank_computer
  import stfq_pkg::*;
#(
  parameter int FLOWS = 10,
  parameter int SIZE  = 50,
  parameter int FID_W = $clog2(FLOWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FID_W-1:0] in_flow,
  input  logic [15:0]      in_len,
  input  logic [31:0]      in_value,
  input  logic             cfg_wr,
  input  logic [FID_W-1:0] cfg_flow,
  input  logic [15:0]      cfg_cost,
  input  logic             deq_valid,
  input  logic [FID_W-1:0] deq_flow,
  input  logic [31:0]      deq_rank,
  output logic             push,
  output logic [31:0]      push_rank,
  output logic [31:0]      push_value,
  output logic [FLOWS-1:0] push_flow,
  output logic             drop_err
);

  rank_t            vtime_r;
  rank_t            last_finish_r [FLOWS];
  cost_t            cost_r [FLOWS];
  logic             push_r;
  rank_t            push_rank_r;
  logic [31:0]      push_value_r;
  logic [FLOWS-1:0] push_flow_r;
  logic             drop_err_r;

  logic             flow_ok_s;
  logic             deq_ok_s;
  logic             cfg_ok_s;
  logic             accept_s;
  logic             push_en_s;
  logic [FID_W-1:0] flow_idx_s;
  logic [FLOWS-1:0] full_s;
  rank_t            ev_s;
  rank_t            start_s;
  rank_t            prod_s;
  rank_t            finish_s;

  // Handshake, range checks and the rank arithmetic for the offered packet.
  always_comb begin
    flow_ok_s  = int'(in_flow) < FLOWS;
    deq_ok_s   = deq_valid && (int'(deq_flow) < FLOWS);
    cfg_ok_s   = cfg_wr && (int'(cfg_flow) < FLOWS);
    flow_idx_s = flow_ok_s ? in_flow : {FID_W{1'b0}};
    in_ready   = !rst && (!flow_ok_s || !full_s[flow_idx_s]);
    accept_s   = in_valid && in_ready;
    push_en_s  = accept_s && flow_ok_s;
    // A same-cycle dequeue advances virtual time for this packet already.
    ev_s       = (deq_valid && (deq_rank > vtime_r)) ? deq_rank : vtime_r;
    start_s    = (last_finish_r[flow_idx_s] > ev_s) ? last_finish_r[flow_idx_s] : ev_s;
    prod_s     = rank_t'(in_len) * rank_t'(cost_r[flow_idx_s]);
    finish_s   = sat_add(start_s, prod_s);
  end

  flow_occupancy #(
    .FLOWS (FLOWS),
    .SIZE  (SIZE),
    .FID_W (FID_W)
  ) u_occ (
    .clk      (clk),
    .rst      (rst),
    .inc      (push_en_s),
    .inc_flow (flow_idx_s),
    .dec      (deq_ok_s),
    .dec_flow (deq_flow),
    .full     (full_s)
  );

  // Flow state, virtual time and the registered push interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      vtime_r      <= 32'd0;
      push_r       <= 1'b0;
      push_rank_r  <= 32'd0;
      push_value_r <= 32'd0;
      push_flow_r  <= {FLOWS{1'b0}};
      drop_err_r   <= 1'b0;
      for (int i = 0; i < FLOWS; i++) begin
        last_finish_r[i] <= 32'd0;
        cost_r[i]        <= 16'd1;
      end
    end else begin
      push_r     <= push_en_s;
      drop_err_r <= accept_s && !flow_ok_s;
      if (push_en_s) begin
        push_rank_r               <= start_s;
        push_value_r              <= in_value;
        push_flow_r               <= {{(FLOWS-1){1'b0}}, 1'b1} << flow_idx_s;
        last_finish_r[flow_idx_s] <= finish_s;
      end
      if (cfg_ok_s) begin
        cost_r[cfg_flow] <= cfg_cost;
      end
      if (deq_valid && (deq_rank > vtime_r)) begin
        vtime_r <= deq_rank;
      end
    end
  end

  assign push       = push_r;
  assign push_rank  = push_rank_r;
  assign push_value = push_value_r;
  assign push_flow  = push_flow_r;
  assign drop_err   = drop_err_r;

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Directed bench for stfq_rank_computer: a per-cycle reference model plus literal spot checks.
module tb_stfq_rank_computer;

  localparam int FLOWS = 10;
  localparam int SIZE  = 50;
  localparam int FID_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [FID_W-1:0] in_flow;
  logic [15:0]      in_len;
  logic [31:0]      in_value;
  logic             cfg_wr;
  logic [FID_W-1:0] cfg_flow;
  logic [15:0]      cfg_cost;
  logic             deq_valid;
  logic [FID_W-1:0] deq_flow;
  logic [31:0]      deq_rank;
  logic             push;
  logic [31:0]      push_rank;
  logic [31:0]      push_value;
  logic [FLOWS-1:0] push_flow;
  logic             drop_err;

  always #5 clk = ~clk;

  stfq_rank_computer #(.FLOWS(FLOWS), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flow(in_flow), .in_len(in_len), .in_value(in_value),
    .cfg_wr(cfg_wr), .cfg_flow(cfg_flow), .cfg_cost(cfg_cost),
    .deq_valid(deq_valid), .deq_flow(deq_flow), .deq_rank(deq_rank),
    .push(push), .push_rank(push_rank), .push_value(push_value),
    .push_flow(push_flow), .drop_err(drop_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: STFQ state kept as plain integers.
  longint unsigned  m_vt, m_start, m_fin;
  longint unsigned  m_lf [FLOWS];
  int               m_cost [FLOWS];
  int               m_occ [FLOWS];
  int               mf;
  bit               m_acc;
  bit               model_ok = 1'b0;
  logic             e_push, e_drop;
  logic [31:0]      e_rank, e_value;
  logic [FLOWS-1:0] e_flow;

  always @(posedge clk) begin
    if (rst) begin
      m_vt = 0;
      for (int i = 0; i < FLOWS; i++) begin
        m_lf[i] = 0; m_cost[i] = 1; m_occ[i] = 0;
      end
      e_push = 1'b0; e_drop = 1'b0; e_rank = 32'd0; e_value = 32'd0; e_flow = '0;
      model_ok = 1'b1;
    end else begin
      mf = int'(in_flow);
      m_acc = in_valid && (mf >= FLOWS || m_occ[mf] < SIZE);
      e_push = 1'b0;
      e_drop = 1'b0;
      if (m_acc && mf >= FLOWS) begin
        e_drop = 1'b1;
      end else if (m_acc) begin
        m_start = m_vt;
        if (deq_valid && deq_rank > m_start) m_start = deq_rank;
        if (m_lf[mf] > m_start) m_start = m_lf[mf];
        m_fin = m_start + longint'(in_len) * longint'(m_cost[mf]);
        if (m_fin > 64'hFFFF_FFFF) m_fin = 64'hFFFF_FFFF;
        e_push  = 1'b1;
        e_rank  = m_start[31:0];
        e_value = in_value;
        e_flow  = '0;
        e_flow[mf] = 1'b1;
        m_lf[mf] = m_fin;
        m_occ[mf]++;
      end
      if (cfg_wr && int'(cfg_flow) < FLOWS) m_cost[cfg_flow] = int'(cfg_cost);
      if (deq_valid && deq_rank > m_vt) m_vt = deq_rank;
      if (deq_valid && int'(deq_flow) < FLOWS && m_occ[deq_flow] > 0) m_occ[deq_flow]--;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("push", push, e_push);
      check("drop_err", drop_err, e_drop);
      check("push_rank", push_rank, e_rank);
      check("push_value", push_value, e_value);
      check("push_flow", push_flow, e_flow);
      check("in_ready", in_ready,
            !rst && (int'(in_flow) >= FLOWS || m_occ[in_flow] < SIZE));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flow = 4'd0; in_len = 16'd0; in_value = 32'd0;
    cfg_wr = 1'b0; cfg_flow = 4'd0; cfg_cost = 16'd0;
    deq_valid = 1'b0; deq_flow = 4'd0; deq_rank = 32'd0;
    tick(); tick();
    check("rst_push", push, 32'd0);
    check("rst_ready", in_ready, 32'd0);
    rst = 1'b0;

    // back-to-back accepts to flow 2
    in_valid = 1'b1; in_flow = 4'd2; in_len = 16'd100; in_value = 32'hA0;
    tick();
    check("f2_push", push, 32'd1);
    check("f2_rank0", push_rank, 32'd0);
    check("f2_onehot", push_flow, 32'b0000000100);
    check("model_lf2", m_lf[2][31:0], 32'd100);
    in_value = 32'hA1;
    tick();
    check("f2_rank1", push_rank, 32'd100);
    check("f2_value1", push_value, 32'hA1);
    in_valid = 1'b0;
    tick();
    check("idle_push", push, 32'd0);

    // cost config, then bypass and registered vtime
    cfg_wr = 1'b1; cfg_flow = 4'd3; cfg_cost = 16'd4; tick();
    cfg_flow = 4'd4; tick();
    cfg_wr = 1'b0;
    in_valid = 1'b1; in_flow = 4'd4; in_len = 16'd10;
    deq_valid = 1'b1; deq_flow = 4'd9; deq_rank = 32'd500;
    tick();
    check("bypass_rank", push_rank, 32'd500);
    check("model_lf4", m_lf[4][31:0], 32'd540);
    deq_valid = 1'b0; in_flow = 4'd3;
    tick();
    check("f3_rank", push_rank, 32'd500);
    check("model_lf3", m_lf[3][31:0], 32'd540);
    cfg_wr = 1'b1; cfg_flow = 4'd3; cfg_cost = 16'd1;
    tick();
    check("f3_rank2", push_rank, 32'd540);
    cfg_wr = 1'b0;
    tick();
    check("old_cost_used", push_rank, 32'd580);

    // fill flow 1
    in_flow = 4'd1; in_len = 16'd0;
    for (int i = 0; i < SIZE; i++) tick();
    in_valid = 1'b0; #1;
    check("full_ready_f1", in_ready, 32'd0);
    in_flow = 4'd0; #1;
    check("ready_f0", in_ready, 32'd1);
    deq_valid = 1'b1; deq_flow = 4'd1; deq_rank = 32'd0;
    tick();
    deq_valid = 1'b0; in_flow = 4'd1; #1;
    check("ready_after_deq", in_ready, 32'd1);
    in_valid = 1'b1; deq_valid = 1'b1;
    tick();
    in_valid = 1'b0; deq_valid = 1'b0; #1;
    check("ready_acc_deq", in_ready, 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check("refull_ready", in_ready, 32'd0);

    // out-of-range flow and stale dequeue rank
    in_valid = 1'b1; in_flow = 4'd10;
    tick();
    check("drop_pulse", drop_err, 32'd1);
    check("drop_nopush", push, 32'd0);
    in_valid = 1'b0;
    tick();
    check("drop_clear", drop_err, 32'd0);
    deq_valid = 1'b1; deq_flow = 4'd0; deq_rank = 32'd10;
    tick();
    deq_valid = 1'b0; in_valid = 1'b1; in_flow = 4'd6; in_len = 16'd0;
    tick();
    check("vtime_mono", push_rank, 32'd500);
    in_valid = 1'b0;

    // saturation near the top of the rank space
    deq_valid = 1'b1; deq_flow = 4'd15; deq_rank = 32'hFFFF_FF00;
    tick();
    deq_valid = 1'b0; in_valid = 1'b1; in_flow = 4'd7; in_len = 16'd1000;
    tick();
    check("sat_start", push_rank, 32'hFFFF_FF00);
    check("model_sat", m_lf[7][31:0], 32'hFFFF_FFFF);
    in_len = 16'd0;
    tick();
    check("sat_rank", push_rank, 32'hFFFF_FFFF);

    // reset mid-stream
    in_flow = 4'd8; in_len = 16'd5; in_value = 32'hBEEF;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_push", push, 32'd0);
    check("mid_rst_rank", push_rank, 32'd0);
    check("mid_rst_flow", push_flow, 32'd0);
    check("mid_rst_ready", in_ready, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_flow = 4'd2;
    tick();
    check("post_rst_rank", push_rank, 32'd0);
    in_valid = 1'b0; in_flow = 4'd1; #1;
    check("post_rst_ready", in_ready, 32'd1);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
